// File: rtl/rca_accumulator_pkg.sv
// Shared definitions for the ripple-carry accumulator.
//   state_e        : controller state encoding (IDLE=0, ACCUM=1, HOLD=2)
//   can_accept()   : true in the states where an operand may be taken
package rca_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic logic can_accept(input state_e s);
    return (s == IDLE) || (s == ACCUM);
  endfunction

endpackage

// File: rtl/rca_n.sv
// N-bit ripple-carry adder built from a chain of full adders.
//   A, B : N-bit addends
//   Cin  : carry into bit 0
//   S    : N-bit sum
//   Cout : carry out of bit N-1
module rca_n #(
  parameter int N = 6
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
);

  logic [N:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[N];

endmodule

// File: rtl/rca_accumulator.sv
// Multi-operand accumulator: sums a burst of unsigned operands through a
// ripple-carry adder and presents the result on a second handshake.
//   clk, rst_n                      : clock, async active-low reset
//   in_valid/in_ready/in_data/in_last : operand stream, in_last marks final beat
//   out_valid/out_ready             : result handshake
//   out_sum   : sum modulo 2^ACC_WIDTH
//   out_ovf   : sticky carry-out seen during the burst
//   out_count : operands accepted, saturating
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | accumulator cleared, waiting for first beat
// ACCUM | burst in progress, summing operands
// HOLD  | result presented until the consumer takes it
module rca_accumulator
  import rca_accumulator_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int ACC_WIDTH = 6,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf,
  output logic [CNT_WIDTH-1:0] out_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;

  logic [ACC_WIDTH-1:0]   operand_ext;
  logic [ACC_WIDTH-1:0]   add_sum;
  logic                   add_cout;
  logic                   accept;

  always_comb begin
    operand_ext              = '0;
    operand_ext[WIDTH-1:0]   = in_data;
  end

  rca_n #(
    .N (ACC_WIDTH)
  ) u_adder (
    .A    (acc_q),
    .B    (operand_ext),
    .Cin  (1'b0),
    .S    (add_sum),
    .Cout (add_cout)
  );

  // in_ready_q is registered and always equals "state is not HOLD", so it
  // doubles as the accept qualifier without a decode on state_q.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = add_sum;
          ovf_d   = ovf_q | add_cout;
          count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        ovf_d   = 1'b0;
        count_d = '0;
      end
    endcase

    // Handshake outputs follow the next state so they line up with the
    // edge that enters or leaves HOLD.
    out_valid_d = (state_d == HOLD);
    in_ready_d  = can_accept(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_rca_accumulator.sv
module tb_rca_accumulator;

  localparam int WIDTH     = 3;
  localparam int ACC_WIDTH = 6;
  localparam int CNT_WIDTH = 4;
  localparam int ACC_MOD   = 1 << ACC_WIDTH;
  localparam int CNT_SAT   = (1 << CNT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic                 out_ovf;
  logic [CNT_WIDTH-1:0] out_count;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int ops_q[$];

  always #5 clk = ~clk;

  rca_accumulator #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Called just after a falling edge; the beat is taken on the next rising edge.
  task automatic send_beat(input int d, input bit last);
    logic [31:0] dv;
    dv = d;
    check("in_ready_at_beat", {31'b0, in_ready}, 1);
    in_valid = 1'b1;
    in_data  = dv[WIDTH-1:0];
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Sends ops_q as one burst, checks the presented result against the
  // arithmetic reference, holds for hold_cycles with backpressure, then
  // releases and checks the return to an empty accumulator.
  task automatic run_burst(input int stall_max, input int hold_cycles);
    int total;
    int n;
    int exp_sum;
    int exp_ovf;
    int exp_cnt;
    total = 0;
    n = ops_q.size();
    for (int i = 0; i < n; i++) begin
      total += ops_q[i];
      if (stall_max > 0) begin
        int gaps;
        gaps = $urandom_range(stall_max, 0);
        for (int g = 0; g < gaps; g++) begin
          in_last = $urandom_range(1, 0) == 1;  // in_last alone must be ignored
          @(negedge clk);
          in_last = 1'b0;
        end
      end
      send_beat(ops_q[i], i == n - 1);
      if (i != n - 1) check("out_valid_mid_burst", {31'b0, out_valid}, 0);
    end

    exp_sum = total % ACC_MOD;
    exp_ovf = (total >= ACC_MOD) ? 1 : 0;
    exp_cnt = (n > CNT_SAT) ? CNT_SAT : n;

    check("out_valid_result", {31'b0, out_valid}, 1);
    check("out_sum",          {26'b0, out_sum}, exp_sum);
    check("out_ovf",          {31'b0, out_ovf}, exp_ovf);
    check("out_count",        {28'b0, out_count}, exp_cnt);
    check("in_ready_hold",    {31'b0, in_ready}, 0);

    for (int h = 0; h < hold_cycles; h++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'($urandom_range(7, 1));
      @(negedge clk);
      check("hold_valid",    {31'b0, out_valid}, 1);
      check("hold_sum",      {26'b0, out_sum}, exp_sum);
      check("hold_count",    {28'b0, out_count}, exp_cnt);
      check("hold_in_ready", {31'b0, in_ready}, 0);
    end

    // Offer an operand in the release cycle too: it must not be taken.
    in_valid  = 1'b1;
    in_data   = 3'd7;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    check("release_valid",    {31'b0, out_valid}, 0);
    check("release_sum",      {26'b0, out_sum}, 0);
    check("release_ovf",      {31'b0, out_ovf}, 0);
    check("release_count",    {28'b0, out_count}, 0);
    check("release_in_ready", {31'b0, in_ready}, 1);
    ops_q.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    #12;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_sum",   {26'b0, out_sum}, 0);
    check("rst_out_ovf",   {31'b0, out_ovf}, 0);
    check("rst_out_count", {28'b0, out_count}, 0);
    check("rst_in_ready",  {31'b0, in_ready}, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // basic burst 5, 7, 4 -> 16
    ops_q = '{5, 7, 4};
    run_burst(0, 0);

    // overflow: ten sevens -> 70 mod 64 = 6, ovf set
    for (int i = 0; i < 10; i++) ops_q.push_back(7);
    run_burst(0, 0);

    // count saturation: twenty ones
    for (int i = 0; i < 20; i++) ops_q.push_back(1);
    run_burst(0, 0);

    // backpressure: 3, 2 held for 5 cycles, then a fresh single beat
    ops_q = '{3, 2};
    run_burst(0, 5);
    ops_q = '{1};
    run_burst(0, 0);

    // single beat
    ops_q = '{3};
    run_burst(0, 1);

    // reset mid-burst, asserted and released between clock edges
    send_beat(6, 1'b0);
    send_beat(6, 1'b0);
    check("live_sum_before_rst", {26'b0, out_sum}, 12);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 0);
    check("midrst_out_sum",   {26'b0, out_sum}, 0);
    check("midrst_out_count", {28'b0, out_count}, 0);
    check("midrst_in_ready",  {31'b0, in_ready}, 1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    ops_q = '{1, 1};
    run_burst(0, 0);

    // randomized bursts with input stalls and backpressure
    for (int b = 0; b < 12; b++) begin
      int len;
      len = $urandom_range(22, 1);
      for (int i = 0; i < len; i++) ops_q.push_back($urandom_range(7, 0));
      run_burst(2, $urandom_range(3, 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
